// File: rtl/idct_pkg.sv
// Shared constants and sizing helpers for the streaming 8-point integer IDCT.
// Cosine constants are round(64*cos(k*pi/16)).
package idct_pkg;

    localparam int C1 = 63;
    localparam int C2 = 59;
    localparam int C3 = 53;
    localparam int C4 = 45;
    localparam int C5 = 36;
    localparam int C6 = 24;
    localparam int C7 = 12;

    // Headroom above the coefficient width so no butterfly stage can wrap.
    localparam int unsigned GuardBits = 10;

    function automatic int unsigned acc_width(input int unsigned cw);
        return cw + GuardBits;
    endfunction

    // Scale back by 2^6 per 1-D pass, a further /2, plus the input fraction.
    function automatic int unsigned round_shift(input int unsigned f);
        return f + 7;
    endfunction

    function automatic longint round_offset(input int unsigned f);
        return longint'(1) << (f + 6);
    endfunction

endpackage

// File: rtl/idct_round_sat.sv
// Half-up rounding, arithmetic right shift and saturation of one IDCT sum
// down to an OW-bit signed sample.
module idct_round_sat
    import idct_pkg::*;
#(
    parameter int unsigned IW = 30,
    parameter int unsigned F  = 8,
    parameter int unsigned OW = 9
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout
);

    localparam int unsigned          Sh   = round_shift(F);
    localparam logic signed [IW-1:0] Off  = IW'(round_offset(F));
    localparam logic signed [IW-1:0] MaxV = IW'((longint'(1) << (OW - 1)) - 1);
    localparam logic signed [IW-1:0] MinV = IW'(-(longint'(1) << (OW - 1)));

    logic signed [IW-1:0] sum;
    logic signed [IW-1:0] shifted;

    always_comb begin
        sum     = din + Off;
        shifted = sum >>> Sh;
        if (shifted > MaxV) begin
            dout = MaxV[OW-1:0];
        end else if (shifted < MinV) begin
            dout = MinV[OW-1:0];
        end else begin
            dout = shifted[OW-1:0];
        end
    end

endmodule

// File: rtl/idct_1d_stream.sv
// Streaming 8-point 1-D inverse DCT: even/odd butterfly, 4-stage pipeline under a
// single global enable, valid/ready on both sides and per-block row framing.
module idct_1d_stream
    import idct_pkg::*;
#(
    parameter int unsigned CW = 20,
    parameter int unsigned F  = 8,
    parameter int unsigned OW = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [CW-1:0] X0,
    input  logic signed [CW-1:0] X1,
    input  logic signed [CW-1:0] X2,
    input  logic signed [CW-1:0] X3,
    input  logic signed [CW-1:0] X4,
    input  logic signed [CW-1:0] X5,
    input  logic signed [CW-1:0] X6,
    input  logic signed [CW-1:0] X7,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] x0,
    output logic signed [OW-1:0] x1,
    output logic signed [OW-1:0] x2,
    output logic signed [OW-1:0] x3,
    output logic signed [OW-1:0] x4,
    output logic signed [OW-1:0] x5,
    output logic signed [OW-1:0] x6,
    output logic signed [OW-1:0] x7,
    output logic [2:0]           out_row,
    output logic                 out_last
);

    localparam int unsigned IW = acc_width(CW);
    typedef logic signed [IW-1:0] acc_t;

    localparam acc_t K1 = acc_t'(C1);
    localparam acc_t K2 = acc_t'(C2);
    localparam acc_t K3 = acc_t'(C3);
    localparam acc_t K4 = acc_t'(C4);
    localparam acc_t K5 = acc_t'(C5);
    localparam acc_t K6 = acc_t'(C6);
    localparam acc_t K7 = acc_t'(C7);

    logic adv;
    acc_t xe   [8];
    acc_t s1_d [8];
    acc_t s2_d [8];
    acc_t s3_d [8];
    acc_t p1_q [8];
    acc_t p2_q [8];
    acc_t p3_q [8];
    logic v1_q, v2_q, v3_q, out_valid_q;
    logic signed [OW-1:0] rs  [8];
    logic signed [OW-1:0] x_q [8];
    logic [2:0] row_q;

    assign xe[0] = acc_t'(X0);
    assign xe[1] = acc_t'(X1);
    assign xe[2] = acc_t'(X2);
    assign xe[3] = acc_t'(X3);
    assign xe[4] = acc_t'(X4);
    assign xe[5] = acc_t'(X5);
    assign xe[6] = acc_t'(X6);
    assign xe[7] = acc_t'(X7);

    // Slots 0..3 carry the even part (a, then e), slots 4..7 the odd terms o0..o3.
    always_comb begin
        s1_d[0] = K4 * (xe[0] + xe[4]);
        s1_d[1] = K4 * (xe[0] - xe[4]);
        s1_d[2] = K2 * xe[2] + K6 * xe[6];
        s1_d[3] = K6 * xe[2] - K2 * xe[6];
        s1_d[4] = K1 * xe[1] + K3 * xe[3] + K5 * xe[5] + K7 * xe[7];
        s1_d[5] = K3 * xe[1] - K7 * xe[3] - K1 * xe[5] - K5 * xe[7];
        s1_d[6] = K5 * xe[1] - K1 * xe[3] + K7 * xe[5] + K3 * xe[7];
        s1_d[7] = K7 * xe[1] - K5 * xe[3] + K3 * xe[5] - K1 * xe[7];

        s2_d[0] = p1_q[0] + p1_q[2];
        s2_d[3] = p1_q[0] - p1_q[2];
        s2_d[1] = p1_q[1] + p1_q[3];
        s2_d[2] = p1_q[1] - p1_q[3];
        for (int i = 4; i < 8; i++) begin
            s2_d[i] = p1_q[i];
        end

        for (int i = 0; i < 4; i++) begin
            s3_d[i]     = p2_q[i] + p2_q[i+4];
            s3_d[7 - i] = p2_q[i] - p2_q[i+4];
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_rs
        idct_round_sat #(
            .IW(IW),
            .F (F),
            .OW(OW)
        ) u_rs (
            .din (p3_q[i]),
            .dout(rs[i])
        );
    end

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk) begin
        if (adv) begin
            p1_q <= s1_d;
            p2_q <= s2_d;
            p3_q <= s3_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_valid_q <= 1'b0;
            row_q       <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            if (adv) begin
                v1_q        <= in_valid;
                v2_q        <= v1_q;
                v3_q        <= v2_q;
                out_valid_q <= v3_q;
                if (v3_q) begin
                    x_q <= rs;
                end
            end
            if (out_valid_q && out_ready) begin
                row_q <= row_q + 3'd1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_row   = row_q;
    assign out_last  = out_valid_q && (row_q == 3'd7);
    assign x0 = x_q[0];
    assign x1 = x_q[1];
    assign x2 = x_q[2];
    assign x3 = x_q[3];
    assign x4 = x_q[4];
    assign x5 = x_q[5];
    assign x6 = x_q[6];
    assign x7 = x_q[7];

endmodule

// File: tb/tb_idct_1d_stream.sv
// Scoreboard bench for idct_1d_stream: the driver queues expected rows on
// acceptance, a negedge monitor checks every presented output row and framing.
module tb_idct_1d_stream;

    localparam int unsigned CW = 20;
    localparam int unsigned F  = 8;
    localparam int unsigned OW = 9;

    typedef logic [7:0][8:0] row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [CW-1:0] X0 = '0, X1 = '0, X2 = '0, X3 = '0;
    logic signed [CW-1:0] X4 = '0, X5 = '0, X6 = '0, X7 = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic signed [OW-1:0] x0, x1, x2, x3, x4, x5, x6, x7;
    logic [2:0] out_row;
    logic out_last;

    int checks = 0;
    int fails = 0;
    row_t sb[$];
    logic [2:0] exp_row = 3'd0;
    int last_hs = 0;
    logic bp_mode = 1'b0;
    int bp_cnt = 0;
    row_t mon_act;

    idct_1d_stream #(
        .CW(CW),
        .F (F),
        .OW(OW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .X0(X0), .X1(X1), .X2(X2), .X3(X3), .X4(X4), .X5(X5), .X6(X6), .X7(X7),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
        .out_row  (out_row),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    // Back-pressure pattern 1,0,0,1 when enabled, otherwise always ready.
    always @(posedge clk) begin
        #1;
        bp_cnt++;
        if (!bp_mode) out_ready = 1'b1;
        else out_ready = ((bp_cnt % 4) == 0) || ((bp_cnt % 4) == 3);
    end

    function automatic row_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
        row_t r;
        r[0] = 9'(a0); r[1] = 9'(a1); r[2] = 9'(a2); r[3] = 9'(a3);
        r[4] = 9'(a4); r[5] = 9'(a5); r[6] = 9'(a6); r[7] = 9'(a7);
        return r;
    endfunction

    function automatic longint cval(input int m);
        case (m)
            0: return 64;
            1: return 63;
            2: return 59;
            3: return 53;
            4: return 45;
            5: return 36;
            6: return 24;
            7: return 12;
            default: return 0;
        endcase
    endfunction

    // Direct matrix form: weight of coefficient k in sample n.
    function automatic longint wgt(input int k, input int n);
        int m;
        if (k == 0) return 45;
        m = (k * (2 * n + 1)) % 32;
        if (m <= 8) return cval(m);
        else if (m <= 16) return -cval(16 - m);
        else if (m <= 24) return -cval(m - 16);
        else return cval(32 - m);
    endfunction

    function automatic row_t model(input int xi[8]);
        row_t r;
        longint s, v;
        for (int n = 0; n < 8; n++) begin
            s = 0;
            for (int k = 0; k < 8; k++) s += wgt(k, n) * longint'(xi[k]);
            v = (s + 64'sd16384) >>> 15;
            if (v > 255) v = 255;
            else if (v < -256) v = -256;
            r[n] = 9'(v);
        end
        return r;
    endfunction

    task automatic send_row(input int xi[8], input row_t exp);
        int n;
        X0 = CW'(xi[0]); X1 = CW'(xi[1]); X2 = CW'(xi[2]); X3 = CW'(xi[3]);
        X4 = CW'(xi[4]); X5 = CW'(xi[5]); X6 = CW'(xi[6]); X7 = CW'(xi[7]);
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 1000);
        checks++;
        if (!in_ready) begin
            fails++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end else begin
            sb.push_back(exp);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_%s: %0d rows outstanding, required 0", name, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_row !== 3'd0 ||
            {x7, x6, x5, x4, x3, x2, x1, x0} !== '0) begin
            fails++;
            $display("FAIL %s: out_valid=%0b out_last=%0b out_row=%0d x=%h, required all zero",
                     name, out_valid, out_last, out_row, {x7, x6, x5, x4, x3, x2, x1, x0});
        end
    endtask

    // Monitor: compares whatever is presented (stalled or not) against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_row = 3'd0;
            last_hs = 0;
        end else begin
            mon_act = {x7, x6, x5, x4, x3, x2, x1, x0};
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                fails++;
                $display("FAIL in_ready: got %0b, required %0b", in_ready, !out_valid || out_ready);
            end
            if (out_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_row: got %h, required no output", mon_act);
                end else if (mon_act !== sb[0]) begin
                    fails++;
                    $display("FAIL row_data: got %h, required %h", mon_act, sb[0]);
                end
                checks++;
                if (out_row !== exp_row || out_last !== (exp_row == 3'd7)) begin
                    fails++;
                    $display("FAIL framing: out_row=%0d out_last=%0b, required %0d %0b",
                             out_row, out_last, exp_row, exp_row == 3'd7);
                end
                if (out_ready) begin
                    if (sb.size() != 0) void'(sb.pop_front());
                    if (out_last) last_hs++;
                    exp_row = exp_row + 3'd1;
                end
            end else begin
                checks++;
                if (out_last !== 1'b0) begin
                    fails++;
                    $display("FAIL last_idle: out_last=%0b, required 0", out_last);
                end
            end
        end
    end

    initial begin
        int v[8];
        int lat;

        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_state");
        rst = 1'b0;

        // Hand-computed directed vectors.
        v = '{2048, 0, 0, 0, 0, 0, 0, 0};
        send_row(v, mk(3, 3, 3, 3, 3, 3, 3, 3));
        v = '{0, 2048, 0, 0, 0, 0, 0, 0};
        send_row(v, mk(4, 3, 2, 1, -1, -2, -3, -4));
        v = '{524287, 0, 0, 0, 0, 0, 0, 0};
        send_row(v, mk(255, 255, 255, 255, 255, 255, 255, 255));
        v = '{-524288, 0, 0, 0, 0, 0, 0, 0};
        send_row(v, mk(-256, -256, -256, -256, -256, -256, -256, -256));
        drain("directed");

        // Ten distinct rows under 1,0,0,1 back-pressure.
        bp_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 8; k++)
                v[k] = ((k % 2) == 1 ? -1 : 1) * (i * 1100 + k * 777 + 300);
            send_row(v, model(v));
        end
        drain("backpressure");
        bp_mode = 1'b0;
        @(posedge clk);
        #1;

        // Reset with three rows in flight and a row offered during reset.
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 8; k++) v[k] = (i + 1) * 3000 - k * 500;
            send_row(v, model(v));
        end
        rst = 1'b1;
        in_valid = 1'b1;
        X0 = 20'sd100000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        check_idle("mid_reset");

        v = '{2048, 0, 0, 0, 0, 0, 0, 0};
        send_row(v, mk(3, 3, 3, 3, 3, 3, 3, 3));
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        checks++;
        if (lat != 4) begin
            fails++;
            $display("FAIL latency: got %0d cycles, required 4", lat);
        end
        drain("after_reset");

        // Block framing over two full blocks.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 8; k++) v[k] = (i * 2311 + k * 4099) % 20000 - 10000;
            send_row(v, model(v));
        end
        drain("framing");
        checks++;
        if (last_hs != 2) begin
            fails++;
            $display("FAIL last_count: got %0d out_last handshakes, required 2", last_hs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
